// File: rtl/stat_display.sv
// stat_display: four-digit multiplexed seven-segment view of one pet stat.
// Layout, left to right: stat_name glyph, state glyph, BCD tens (blank below 10), BCD units.
module stat_display #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int          COMMON_ANODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] stat_name,
    input  logic [5:0] stat_value,
    input  logic [3:0] state,
    output logic [6:0] sseg,
    output logic [3:0] an,
    output logic       conv_busy
);

    localparam int unsigned PW         = $clog2(REFRESH_DIV);
    localparam bit          ACTIVE_LOW = (COMMON_ANODE != 0);
    localparam logic [6:0]  SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF     = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} conv_state_t;

    conv_state_t cs_q, cs_d;

    logic [5:0]    bin_q;
    logic [5:0]    cap_q;
    logic [5:0]    last_q;
    logic [3:0]    tens_bcd_q;
    logic [3:0]    units_bcd_q;
    logic [2:0]    iter_q;
    logic          force_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic [3:0]    name_q;
    logic [3:0]    pstate_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;

    logic [3:0]  tens_adj;
    logic [3:0]  units_adj;
    logic [13:0] shifted;
    logic [6:0]  seg_raw;
    logic [3:0]  an_raw;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign conv_busy = (cs_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q <= IDLE;
        end else begin
            cs_q <= cs_d;
        end
    end

    always_comb begin
        cs_d = cs_q;
        case (cs_q)
            IDLE:    if (force_q || (stat_value != last_q)) cs_d = LOAD;
            LOAD:    cs_d = SHIFT;
            SHIFT:   if (iter_q == 3'd1) cs_d = UPDATE;
            UPDATE:  cs_d = IDLE;
            default: cs_d = IDLE;
        endcase
    end

    // Double-dabble step: correct nibbles >= 5 before the shift so they carry as decimal.
    always_comb begin
        tens_adj  = (tens_bcd_q >= 4'd5) ? tens_bcd_q + 4'd3 : tens_bcd_q;
        units_adj = (units_bcd_q >= 4'd5) ? units_bcd_q + 4'd3 : units_bcd_q;
        shifted   = {tens_adj, units_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q       <= '0;
            cap_q       <= '0;
            last_q      <= '0;
            tens_bcd_q  <= '0;
            units_bcd_q <= '0;
            iter_q      <= '0;
            force_q     <= 1'b1;
            tens_q      <= '0;
            units_q     <= '0;
        end else begin
            case (cs_q)
                LOAD: begin
                    bin_q       <= stat_value;
                    cap_q       <= stat_value;
                    tens_bcd_q  <= '0;
                    units_bcd_q <= '0;
                    iter_q      <= 3'd6;
                    force_q     <= 1'b0;
                end
                SHIFT: begin
                    tens_bcd_q  <= shifted[13:10];
                    units_bcd_q <= shifted[9:6];
                    bin_q       <= shifted[5:0];
                    iter_q      <= iter_q - 3'd1;
                end
                UPDATE: begin
                    tens_q  <= tens_bcd_q;
                    units_q <= units_bcd_q;
                    last_q  <= cap_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            name_q   <= '0;
            pstate_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
        end else begin
            name_q   <= stat_name;
            pstate_q <= state;
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    seg_raw = hex_glyph(units_q);
            2'd1:    seg_raw = (tens_q == 4'd0) ? 7'h00 : hex_glyph(tens_q);
            2'd2:    seg_raw = hex_glyph(pstate_q);
            default: seg_raw = hex_glyph(name_q);
        endcase
        an_raw = 4'b0001 << idx_q;
    end

    // an and sseg share one register stage so the enable never leads its segments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sseg <= SEG_OFF;
            an   <= AN_OFF;
        end else begin
            sseg <= ACTIVE_LOW ? ~seg_raw : seg_raw;
            an   <= ACTIVE_LOW ? ~an_raw : an_raw;
        end
    end

endmodule

// File: tb/tb_stat_display.sv
// Bench for stat_display: random and directed stat values, scoreboard of converted
// values checked against the scanned digits of a common-anode and a common-cathode instance.
module tb_stat_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stat_name = '0;
    logic [3:0] state = '0;
    logic [5:0] stat_value = '0;
    logic [6:0] sseg_ca, sseg_cc;
    logic [3:0] an_ca, an_cc;
    logic       busy_ca, busy_cc;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int n_edges = 0;
    int last_conv = 0;
    logic [3:0] name_h1 = '0, name_h2 = '0, st_h1 = '0, st_h2 = '0;

    int         mon_val = 0;
    int         mon_busy_len = 0;
    logic       mon_prev_busy = 1'b0;
    int         mon_d;
    logic [6:0] es, es_n;
    logic [3:0] ea, ea_n;

    always #5 clk = ~clk;

    stat_display #(.REFRESH_DIV(DIV), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .rst(rst), .stat_name(stat_name), .stat_value(stat_value),
        .state(state), .sseg(sseg_ca), .an(an_ca), .conv_busy(busy_ca)
    );

    stat_display #(.REFRESH_DIV(DIV), .COMMON_ANODE(0)) dut_cc (
        .clk(clk), .rst(rst), .stat_name(stat_name), .stat_value(stat_value),
        .state(state), .sseg(sseg_cc), .an(an_cc), .conv_busy(busy_cc)
    );

    function automatic logic [6:0] glyph(input int v);
        case (v & 15)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input int d, input int val,
                                             input logic [3:0] nm, input logic [3:0] st);
        case (d)
            0: return glyph(val % 10);
            1: return (val < 10) ? 7'h00 : glyph(val / 10);
            2: return glyph(int'(st));
            default: return glyph(int'(nm));
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        name_h2 = name_h1;
        name_h1 = stat_name;
        st_h2   = st_h1;
        st_h1   = state;
        if (!rst) n_edges = 0;
        else      n_edges++;
    end

    // Monitor: scan position follows from the edge count; digit contents follow the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_an_ca", an_ca, 4'hF);
                check("rst_sseg_ca", sseg_ca, 7'h7F);
                check("rst_an_cc", an_cc, 4'h0);
                check("rst_sseg_cc", sseg_cc, 7'h00);
                check("rst_busy_ca", busy_ca, 0);
                check("rst_busy_cc", busy_cc, 0);
                mon_val = 0;
                mon_busy_len = 0;
                mon_prev_busy = 1'b0;
            end else if (n_edges >= 1) begin
                mon_d = ((n_edges - 1) / DIV) % 4;
                ea    = 4'b0001 << mon_d;
                ea_n  = ~ea;
                es    = exp_digit(mon_d, mon_val, name_h2, st_h2);
                es_n  = ~es;
                check("an_ca", an_ca, ea_n);
                check("an_cc", an_cc, ea);
                check($sformatf("sseg_ca_d%0d", mon_d), sseg_ca, es_n);
                check($sformatf("sseg_cc_d%0d", mon_d), sseg_cc, es);
                if (busy_ca) begin
                    mon_busy_len++;
                end else if (mon_prev_busy) begin
                    check("busy_len", mon_busy_len, 8);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: conversion finished with no expected value at %0t", $time);
                    end else begin
                        mon_val = exp_q.pop_front();
                    end
                    mon_busy_len = 0;
                end
                mon_prev_busy = busy_ca;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!busy_ca) return;
        end
        check("idle_timeout", busy_ca, 0);
    endtask

    task automatic idle_cycles(input int n, input bit shuffle);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (shuffle && ($urandom_range(0, 3) == 0)) begin
                stat_name = 4'($urandom);
                state     = 4'($urandom);
            end
        end
    endtask

    task automatic apply(input int v);
        int changed;
        wait_idle();
        stat_value = 6'(v);
        changed = (v != last_conv) ? 1 : 0;
        if (changed != 0) begin
            exp_q.push_back(v);
            last_conv = v;
        end
        @(posedge clk);
        #1;
        check("busy_start_ca", busy_ca, changed);
        check("busy_start_cc", busy_cc, changed);
        idle_cycles(36, 1'b1);
    endtask

    initial begin
        int directed[8] = '{37, 63, 5, 10, 9, 0, 0, 63};
        int boundary[4] = '{0, 9, 10, 63};
        int gap;
        int v;

        #1 rst = 1'b0;
        stat_value = '0;
        stat_name  = 4'($urandom);
        state      = 4'($urandom);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.push_back(0);
        last_conv = 0;
        @(posedge clk);
        #1;
        check("busy_after_release", busy_ca, 1);
        idle_cycles(36, 1'b0);

        foreach (directed[i]) apply(directed[i]);

        wait_idle();
        stat_name = 4'hE;
        state     = 4'hA;
        idle_cycles(24, 1'b0);

        // New value lands in the third SHIFT cycle; it must wait for the next IDLE.
        wait_idle();
        stat_value = 6'd20;
        exp_q.push_back(20);
        repeat (4) @(posedge clk);
        #1;
        stat_value = 6'd45;
        exp_q.push_back(45);
        last_conv = 45;
        for (int i = 0; i < 30 && busy_ca; i++) @(negedge clk);
        gap = 0;
        for (int i = 0; i < 5 && !busy_ca; i++) begin
            gap++;
            @(negedge clk);
        end
        check("idle_gap", gap, 1);
        idle_cycles(40, 1'b1);

        wait_idle();
        stat_value = 6'd59;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_an_ca", an_ca, 4'hF);
        check("abort_sseg_ca", sseg_ca, 7'h7F);
        check("abort_an_cc", an_cc, 4'h0);
        check("abort_sseg_cc", sseg_cc, 7'h00);
        check("abort_busy", busy_ca, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.push_back(59);
        last_conv = 59;
        idle_cycles(40, 1'b1);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 3) == 0) v = boundary[$urandom_range(0, 3)];
            else                           v = $urandom_range(0, 63);
            apply(v);
        end

        idle_cycles(10, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stat_display.md
STAT_DISPLAY -- requirements
Module: stat_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clk cycles each digit stays enabled (legal range >= 2).
REQ-002 The block SHALL have parameter COMMON_ANODE, default 1: when 1, sseg and an are active-low; when 0, active-high.
REQ-003 The block SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port stat_name  input  4  selected-stat glyph code (hex) from the stat register bank.
REQ-006 The block SHALL have port stat_value  input  6  selected-stat value, unsigned 0-63.
REQ-007 The block SHALL have port state  input  4  pet state nibble.
REQ-008 The block SHALL have port sseg  output  7  segment drive, bit order {g,f,e,d,c,b,a}, registered.
REQ-009 The block SHALL have port an  output  4  digit enables, one-hot when active, registered; an[0] is the rightmost digit.
REQ-010 The block SHALL have port conv_busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-011 The display layout SHALL be: digit3 = stat_name as hex glyph; digit2 = state as hex glyph; digit1 = BCD tens of stat_value; digit0 = BCD units of stat_value.
REQ-012 The digit1 tens digit SHALL be blanked (all segments off) when the converted value is < 10.
REQ-013 Hex glyphs SHALL be the standard 0-F seven-segment set, internal active-high (e.g., 0x3F for "0", 0x4F for "3", 0x07 for "7", 0x71 for "F"); the output is the bitwise inverse when COMMON_ANODE=1.
REQ-014 The conversion FSM SHALL have states IDLE, LOAD, SHIFT, UPDATE.
REQ-015 IDLE -> LOAD SHALL occur when stat_value differs from the last converted value or the force flag is set; otherwise the FSM stays in IDLE.
REQ-016 LOAD SHALL capture stat_value into the shift register, clear the BCD registers, clear the force flag and set an iteration count of 6.
REQ-017 Each SHIFT cycle SHALL add 3 to any BCD nibble >= 5, then shift {BCD, binary} left one bit; after the 6th shift the FSM SHALL go to UPDATE.
REQ-018 UPDATE SHALL write the tens/units display registers and the last-converted value in a single cycle, then return to IDLE.
REQ-019 Latency from a stat_value change (sampled in IDLE) to updated tens/units registers SHALL be 8 cycles: 1 IDLE, 1 LOAD, 6 SHIFT; the UPDATE edge writes the registers.
REQ-020 stat_value changes during LOAD/SHIFT/UPDATE SHALL NOT disturb the running conversion; the new value SHALL be detected in the next IDLE cycle.
REQ-021 conv_busy SHALL be high in LOAD, SHIFT and UPDATE, and low in IDLE.
REQ-022 stat_name and state SHALL be sampled into display registers every cycle (1-cycle latency, no conversion).
REQ-023 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-024 an and sseg SHALL both change on the same edge, one cycle after the index changes, so that an never shows a stale digit's segments.
REQ-025 Tens/units digit values SHALL be 0-9 only; stat_value 63 SHALL give tens 6, units 3.

Reset
REQ-026 While rst is low: an and sseg SHALL be all off (4'hF / 7'h7F when COMMON_ANODE=1); prescaler, digit index, BCD, shift and display registers SHALL be 0; FSM SHALL be IDLE; conv_busy SHALL be 0; force flag SHALL be 1.
REQ-027 Reset asserted mid-conversion SHALL abort it with no partial result written.
REQ-028 After release, the first IDLE cycle SHALL start a conversion regardless of stat_value.

Verification
REQ-029 REFRESH_DIV=4, COMMON_ANODE=1, release reset with stat_value=0 -> conv_busy high for 8 cycles starting the cycle after release; an cycles 1110,1101,1011,0111, changing every 4 cycles; digit0 sseg=0x40, digit1 sseg=0x7F (blank).
REQ-030 stat_value 0->37 in IDLE -> 8 cycles later tens=3, units=7; digit1 sseg=0x30, digit0 sseg=0x78.
REQ-031 stat_value=63 -> digits "6","3"; stat_value=5 -> digit1 blank, digit0 "5"; stat_value=10 -> "1","0".
REQ-032 stat_value 20->45 on the 3rd SHIFT cycle -> the running conversion completes with 20, then a new conversion yields 45; conv_busy stays low for exactly one IDLE cycle between the two.
REQ-033 Reset pulsed during SHIFT with stat_value=59 -> outputs go off immediately; after release, conversion runs and displays 59.
REQ-034 stat_name=0xE, state=0xA, COMMON_ANODE=0 -> digit3 sseg=0x79, digit2 sseg=0x77, an active-high one-hot.
